ddr2_host_port: RTL and testbench
=================================

# ddr2_host_port

Synthesizable host-side request port that sits directly upstream of ddr2_controller, in place of the behavioural controller_driver. It accepts scalar/block read and write requests plus a write-data stream from a client, buffers block-write data locally, and issues CMD/SZ/OP/ADDR/DIN to the controller only when the controller's input FIFO has room. It also tracks outstanding read words, drives FETCHING, and re-registers returned read data to the client.

## Interface
- WFIFO_DEPTH, 32: local write-data FIFO entries (16-bit each); must be ≥ 32.
- CTRL_DEPTH, 64: controller input-FIFO depth used in the space check.
- MAX_OUTST, 255: maximum outstanding read words; outst counter is 8 bits.
- clk  in  1  system clock; all logic on posedge.
- reset  in  1  asynchronous, active-low reset.
- req_valid / req_ready  in/out  1/1  request handshake; transfer when both are 1 at posedge.
- req_cmd  in  3  000 NOP, 001 SCR, 010 SCW, 011 BLR, 100 BLW; 101–111 illegal.
- req_sz  in  2  block length N = 8·(sz+1) words (8/16/24/32); scalar N = 1.
- req_op  in  3  passed through to op unchanged.
- req_addr  in  25  start address.
- wr_valid / wr_ready  in/out  1/1  write-data push handshake into the local FIFO.
- wr_data  in  16  write word.
- cmd, sz, op, addr, din  out  3, 2, 3, 25, 16  to the controller; all registered.
- fillcount  in  7  controller input-FIFO occupancy.
- notfull  in  1  controller can accept a command.
- fetching  out  1  read-return sink active.
- validout, dout, raddr  in  1, 16, 25  read return from the controller.
- rd_valid, rd_data, rd_addr  out  1, 16, 25  registered read return to the client.
- err  out  1  one-cycle pulse on an illegal command or an unexpected read return.

## Operation
- States: IDLE, ISSUE, STREAM.
- IDLE: req_ready = 1. On acceptance, latch cmd/sz/op/addr, compute N and go to ISSUE.
  - Latched NOP: discard and stay in IDLE.
  - Latched illegal code: err pulse, discard, stay in IDLE; no FIFO words consumed.
- ISSUE: req_ready = 0. Issue at a posedge only when all gates hold:
  - notfull = 1;
  - writes: fillcount + N ≤ CTRL_DEPTH and wfifo count ≥ N;
  - reads: outst + N ≤ MAX_OUTST.
- On issue, register cmd/sz/op/addr for exactly one cycle.
  - Writes: din = wfifo head (popped).
  - Reads: outst += N.
- After a successful issue:
  - SCW/SCR/BLR: return to IDLE.
  - BLW: go to STREAM.
- STREAM: drive words 1..N−1 on din on consecutive cycles with cmd = 000, popping one word per cycle with no gaps, then go to IDLE.
- Outside an issue cycle: cmd = 000, and sz/op/addr/din hold their last values.
- Write FIFO: wr_ready = (count < WFIFO_DEPTH). No write-through when full. A push and a pop in the same cycle leave count unchanged.
- Read return:
  - fetching = (outst ≠ 0).
  - Each validout: outst −= 1, and rd_valid/rd_data/rd_addr are registered one cycle later.
  - validout with outst = 0: err pulse, data still forwarded, counter stays 0 (no wrap).
- Same-cycle read issue and validout: outst += N − 1.
- Reset asserted at any time: abort any burst, flush the write FIFO, clear outst, return to IDLE.

## Timing
- Reset values: cmd = 000, sz = 00, op = 000, addr = 0, din = 0, fetching = 0, rd_valid = 0, rd_data = 0, rd_addr = 0, err = 0.
  - req_ready = 0 and wr_ready = 0 while reset is low.
  - Both become 1 from the first cycle after reset deasserts.
- Issue latency: request accepted at edge E0; earliest cmd visible in the cycle after E1 (two-edge latency when all gates hold).
- BLW occupies N consecutive cycles on din.
- req_ready returns to 1 in the cycle after the last burst word is driven.
- Read return latency: validout → rd_valid is exactly 1 cycle; the returned stream is never stalled.
- Gates are re-evaluated every cycle in ISSUE; the wait is unbounded.

## Test plan
- Reset, then SCW addr 0x0000010 with one word 0xBEEF queued → cmd = 010, addr = 0x0000010, din = 0xBEEF for one cycle, 2 edges after acceptance; req_ready back high the next cycle.
- BLW sz = 01 (N = 16) with 16 words queued and fillcount = 50 → no issue. Then fillcount = 48 → cmd = 100 for one cycle, followed by 15 gapless words with cmd = 000, in FIFO order.
- BLR sz = 11 → outst = 32 and fetching = 1. Apply 32 validout pulses → 32 rd_valid pulses, each 1 cycle later; after the last, fetching = 0.
- req_cmd = 110 → err pulses for one cycle; no controller command; wfifo count unchanged.
- validout while outst = 0 → err = 1, rd_valid = 1 one cycle later, outst stays 0.
- Reset asserted mid-BLW burst (word 5 of 8) → outputs take reset values immediately, wfifo empty, and the first request after reset issues normally.

Source files
------------

// File: rtl/ddr2_host_port.sv
// Host-side request port for ddr2_controller: buffers write data, gates command
// issue on controller FIFO space and read credit, and re-registers read returns.
module ddr2_host_port #(
  parameter int WFIFO_DEPTH = 32,
  parameter int CTRL_DEPTH  = 64,
  parameter int MAX_OUTST   = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_cmd,
  input  logic [1:0]  req_sz,
  input  logic [2:0]  req_op,
  input  logic [24:0] req_addr,
  input  logic        wr_valid,
  output logic        wr_ready,
  input  logic [15:0] wr_data,
  output logic [2:0]  cmd,
  output logic [1:0]  sz,
  output logic [2:0]  op,
  output logic [24:0] addr,
  output logic [15:0] din,
  input  logic [6:0]  fillcount,
  input  logic        notfull,
  output logic        fetching,
  input  logic        validout,
  input  logic [15:0] dout,
  input  logic [24:0] raddr,
  output logic        rd_valid,
  output logic [15:0] rd_data,
  output logic [24:0] rd_addr,
  output logic        err
);

  localparam int AW = $clog2(WFIFO_DEPTH);
  localparam int CW = AW + 1;

  localparam logic [2:0] C_NOP = 3'd0;
  localparam logic [2:0] C_SCR = 3'd1;
  localparam logic [2:0] C_SCW = 3'd2;
  localparam logic [2:0] C_BLR = 3'd3;
  localparam logic [2:0] C_BLW = 3'd4;

  typedef enum logic [1:0] {IDLE, ISSUE, STREAM} state_t;
  state_t state, state_nx;

  logic          alive;
  logic [2:0]    lat_cmd;
  logic [1:0]    lat_sz;
  logic [2:0]    lat_op;
  logic [24:0]   lat_addr;
  logic [5:0]    lat_n;
  logic [4:0]    burst_left;
  logic [7:0]    outst;

  logic [15:0]   wmem [WFIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] wcount;

  logic accept, legal_req, illegal_req, is_wr, is_rd;
  logic wr_gate, rd_gate, issue, push, pop, rd_dec;

  function automatic logic [5:0] burst_len(input logic [2:0] c, input logic [1:0] s);
    if (c == C_BLR || c == C_BLW) return {({1'b0, s} + 3'd1), 3'b000};
    return 6'd1;
  endfunction

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    if (p == AW'(WFIFO_DEPTH - 1)) return '0;
    return p + AW'(1);
  endfunction

  assign accept      = req_valid && req_ready;
  assign legal_req   = (req_cmd != C_NOP) && (req_cmd <= C_BLW);
  assign illegal_req = req_cmd > C_BLW;
  assign is_wr       = (lat_cmd == C_SCW) || (lat_cmd == C_BLW);
  assign is_rd       = (lat_cmd == C_SCR) || (lat_cmd == C_BLR);
  assign wr_gate     = (int'(fillcount) + int'(lat_n) <= CTRL_DEPTH) && (int'(wcount) >= int'(lat_n));
  assign rd_gate     = (int'(outst) + int'(lat_n) <= MAX_OUTST);
  assign issue       = (state == ISSUE) && notfull && (is_wr ? wr_gate : rd_gate);
  assign pop         = (issue && is_wr) || (state == STREAM);
  assign push        = wr_valid && wr_ready;
  assign rd_dec      = validout && (outst != 8'd0);
  assign fetching    = (outst != 8'd0);

  always_comb begin
    state_nx  = state;
    req_ready = 1'b0;
    wr_ready  = alive && (int'(wcount) < WFIFO_DEPTH);
    case (state)
      IDLE: begin
        req_ready = alive;
        if (accept && legal_req) state_nx = ISSUE;
      end
      ISSUE:  if (issue) state_nx = (lat_cmd == C_BLW) ? STREAM : IDLE;
      STREAM: if (burst_left == 5'd1) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nx;
  end

  // Request latch, burst tracking and controller-facing registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      alive      <= 1'b0;
      lat_cmd    <= C_NOP;
      lat_sz     <= '0;
      lat_op     <= '0;
      lat_addr   <= '0;
      lat_n      <= '0;
      burst_left <= '0;
      cmd        <= C_NOP;
      sz         <= '0;
      op         <= '0;
      addr       <= '0;
      din        <= '0;
    end else begin
      alive <= 1'b1;
      cmd   <= C_NOP;
      if (accept) begin
        lat_cmd  <= req_cmd;
        lat_sz   <= req_sz;
        lat_op   <= req_op;
        lat_addr <= req_addr;
        lat_n    <= burst_len(req_cmd, req_sz);
      end
      if (issue) begin
        cmd        <= lat_cmd;
        sz         <= lat_sz;
        op         <= lat_op;
        addr       <= lat_addr;
        burst_left <= 5'(lat_n - 6'd1);
      end else if (state == STREAM) begin
        burst_left <= burst_left - 5'd1;
      end
      if (pop) din <= wmem[rd_ptr];
    end
  end

  // Local write-data FIFO; storage needs no reset since the pointers flush it
  always_ff @(posedge clk) begin
    if (push) wmem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      wcount <= '0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      if (push && !pop)      wcount <= wcount + CW'(1);
      else if (pop && !push) wcount <= wcount - CW'(1);
    end
  end

  // Read credit and read-return register stage
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      outst    <= '0;
      rd_valid <= 1'b0;
      rd_data  <= '0;
      rd_addr  <= '0;
      err      <= 1'b0;
    end else begin
      outst    <= outst + ((issue && is_rd) ? {2'b00, lat_n} : 8'd0) - {7'd0, rd_dec};
      rd_valid <= validout;
      if (validout) begin
        rd_data <= dout;
        rd_addr <= raddr;
      end
      err <= (accept && illegal_req) || (validout && (outst == 8'd0));
    end
  end

endmodule

// File: tb/tb_ddr2_host_port.sv
// Directed bench for ddr2_host_port: inputs driven and outputs sampled on negedge.
module tb_ddr2_host_port;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready;
  logic [2:0]  req_cmd;
  logic [1:0]  req_sz;
  logic [2:0]  req_op;
  logic [24:0] req_addr;
  logic        wr_valid, wr_ready;
  logic [15:0] wr_data;
  logic [2:0]  cmd;
  logic [1:0]  sz;
  logic [2:0]  op;
  logic [24:0] addr;
  logic [15:0] din;
  logic [6:0]  fillcount;
  logic        notfull;
  logic        fetching;
  logic        validout;
  logic [15:0] dout;
  logic [24:0] raddr;
  logic        rd_valid;
  logic [15:0] rd_data;
  logic [24:0] rd_addr;
  logic        err;

  int errors = 0;
  int checks = 0;

  ddr2_host_port dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_cmd(req_cmd), .req_sz(req_sz),
    .req_op(req_op), .req_addr(req_addr),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
    .cmd(cmd), .sz(sz), .op(op), .addr(addr), .din(din),
    .fillcount(fillcount), .notfull(notfull), .fetching(fetching),
    .validout(validout), .dout(dout), .raddr(raddr),
    .rd_valid(rd_valid), .rd_data(rd_data), .rd_addr(rd_addr), .err(err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic push_word(input logic [15:0] d);
    wr_valid = 1'b1;
    wr_data  = d;
    tick();
    wr_valid = 1'b0;
  endtask

  task automatic send_req(input logic [2:0] c, input logic [1:0] s, input logic [2:0] o,
                          input logic [24:0] a);
    req_valid = 1'b1;
    req_cmd   = c;
    req_sz    = s;
    req_op    = o;
    req_addr  = a;
    tick();
    req_valid = 1'b0;
  endtask

  initial begin
    reset = 1'b0;
    req_valid = 1'b0; req_cmd = '0; req_sz = '0; req_op = '0; req_addr = '0;
    wr_valid = 1'b0; wr_data = '0;
    fillcount = '0; notfull = 1'b1;
    validout = 1'b0; dout = '0; raddr = '0;

    // reset state
    tick(); tick();
    chk("rst_cmd", 32'(cmd), 32'h0);
    chk("rst_din", 32'(din), 32'h0);
    chk("rst_addr", 32'(addr), 32'h0);
    chk("rst_req_ready", 32'(req_ready), 32'h0);
    chk("rst_wr_ready", 32'(wr_ready), 32'h0);
    chk("rst_fetching", 32'(fetching), 32'h0);
    chk("rst_rd_valid", 32'(rd_valid), 32'h0);
    chk("rst_err", 32'(err), 32'h0);

    reset = 1'b1;
    tick();
    chk("post_rst_req_ready", 32'(req_ready), 32'h1);
    chk("post_rst_wr_ready", 32'(wr_ready), 32'h1);

    // SCW with one queued word
    push_word(16'hBEEF);
    chk("scw_wcount", 32'(dut.wcount), 32'd1);
    send_req(3'b010, 2'b00, 3'b000, 25'h0000010);
    chk("scw_wait_cmd", 32'(cmd), 32'h0);
    chk("scw_busy_ready", 32'(req_ready), 32'h0);
    tick();
    chk("scw_cmd", 32'(cmd), 32'h2);
    chk("scw_addr", 32'(addr), 32'h10);
    chk("scw_din", 32'(din), 32'hBEEF);
    tick();
    chk("scw_cmd_gone", 32'(cmd), 32'h0);
    chk("scw_din_hold", 32'(din), 32'hBEEF);
    chk("scw_ready_back", 32'(req_ready), 32'h1);
    chk("scw_wcount_empty", 32'(dut.wcount), 32'd0);

    // BLW N=16 blocked by fillcount 50, released at 48
    for (int i = 0; i < 16; i++) push_word(16'h1000 + 16'(i));
    fillcount = 7'd50;
    send_req(3'b100, 2'b01, 3'b010, 25'h0000100);
    tick(); tick(); tick();
    chk("blw_blocked_cmd", 32'(cmd), 32'h0);
    chk("blw_blocked_wcount", 32'(dut.wcount), 32'd16);
    fillcount = 7'd48;
    tick();
    chk("blw_cmd", 32'(cmd), 32'h4);
    chk("blw_sz", 32'(sz), 32'h1);
    chk("blw_op", 32'(op), 32'h2);
    chk("blw_addr", 32'(addr), 32'h100);
    chk("blw_word0", 32'(din), 32'h1000);
    for (int i = 1; i < 16; i++) begin
      tick();
      chk("blw_stream_cmd", 32'(cmd), 32'h0);
      chk("blw_stream_word", 32'(din), 32'h1000 + 32'(i));
    end
    tick();
    chk("blw_ready_back", 32'(req_ready), 32'h1);
    chk("blw_wcount_empty", 32'(dut.wcount), 32'd0);

    // BLR N=32 and its 32 returns
    send_req(3'b011, 2'b11, 3'b101, 25'h0000200);
    tick();
    chk("blr_cmd", 32'(cmd), 32'h3);
    chk("blr_op", 32'(op), 32'h5);
    chk("blr_outst", 32'(dut.outst), 32'd32);
    chk("blr_fetching", 32'(fetching), 32'h1);
    for (int i = 0; i < 32; i++) begin
      validout = 1'b1;
      dout     = 16'h2000 + 16'(i);
      raddr    = 25'h200 + 25'(i);
      tick();
      chk("blr_rd_valid", 32'(rd_valid), 32'h1);
      chk("blr_rd_data", 32'(rd_data), 32'h2000 + 32'(i));
      chk("blr_rd_addr", 32'(rd_addr), 32'h200 + 32'(i));
    end
    validout = 1'b0;
    tick();
    chk("blr_rd_valid_end", 32'(rd_valid), 32'h0);
    chk("blr_fetching_end", 32'(fetching), 32'h0);
    chk("blr_outst_end", 32'(dut.outst), 32'd0);
    chk("blr_no_err", 32'(err), 32'h0);

    // illegal command
    push_word(16'hCAFE);
    send_req(3'b110, 2'b00, 3'b000, 25'h0000333);
    chk("ill_err", 32'(err), 32'h1);
    tick();
    chk("ill_err_pulse", 32'(err), 32'h0);
    chk("ill_cmd", 32'(cmd), 32'h0);
    chk("ill_wcount", 32'(dut.wcount), 32'd1);
    chk("ill_ready", 32'(req_ready), 32'h1);

    // unexpected read return
    validout = 1'b1;
    dout     = 16'h5555;
    raddr    = 25'h7;
    tick();
    validout = 1'b0;
    chk("unexp_err", 32'(err), 32'h1);
    chk("unexp_rd_valid", 32'(rd_valid), 32'h1);
    chk("unexp_rd_data", 32'(rd_data), 32'h5555);
    chk("unexp_outst", 32'(dut.outst), 32'd0);
    tick();
    chk("unexp_err_pulse", 32'(err), 32'h0);
    chk("unexp_fetching", 32'(fetching), 32'h0);

    // reset during an 8-word BLW
    for (int i = 0; i < 7; i++) push_word(16'h3000 + 16'(i));
    send_req(3'b100, 2'b00, 3'b001, 25'h0000400);
    tick();
    chk("blw8_cmd", 32'(cmd), 32'h4);
    chk("blw8_word0", 32'(din), 32'hCAFE);
    for (int i = 1; i < 5; i++) begin
      tick();
      chk("blw8_word", 32'(din), 32'h3000 + 32'(i - 1));
    end
    reset = 1'b0;
    #1;
    chk("midrst_cmd", 32'(cmd), 32'h0);
    chk("midrst_din", 32'(din), 32'h0);
    chk("midrst_addr", 32'(addr), 32'h0);
    chk("midrst_wcount", 32'(dut.wcount), 32'd0);
    chk("midrst_req_ready", 32'(req_ready), 32'h0);
    chk("midrst_wr_ready", 32'(wr_ready), 32'h0);
    tick();
    reset = 1'b1;
    tick();
    chk("after_rst_ready", 32'(req_ready), 32'h1);
    chk("after_rst_cmd", 32'(cmd), 32'h0);
    push_word(16'h7777);
    send_req(3'b010, 2'b00, 3'b000, 25'h0000040);
    tick();
    chk("after_rst_scw_cmd", 32'(cmd), 32'h2);
    chk("after_rst_scw_din", 32'(din), 32'h7777);
    chk("after_rst_scw_addr", 32'(addr), 32'h40);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
